// File: rtl/branch_resolve_unit_rv32i.sv
// Branch resolve unit for RV32I conditional branches.
// Evaluates the branch condition, computes the next fetch address, registers
// the result behind a valid/ready handshake, and raises a multi-cycle flush
// after every taken branch. It also keeps saturating statistics counters.
module branch_resolve_unit_rv32i #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       comp_code,
    input  logic [31:0]      rs1_val,
    input  logic [31:0]      rs2_val,
    input  logic [31:0]      pc,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [31:0]      out_next_pc,
    output logic             out_misalign,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0]       FLUSH_LIM = 4'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Condition evaluation for the decoded compare code; none/reserved never match.
    function automatic logic cond_met(input logic [2:0]  code,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        logic res;
        case (code)
            3'b001:  res = (a == b);
            3'b010:  res = (a != b);
            3'b011:  res = ($signed(a) <  $signed(b));
            3'b100:  res = ($signed(a) >= $signed(b));
            3'b101:  res = (a <  b);
            3'b110:  res = (a >= b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // True for real branch encodings (BEQ..BGEU), which are the ones counted.
    function automatic logic is_branch(input logic [2:0] code);
        logic res;
        case (code)
            3'b001, 3'b010, 3'b011,
            3'b100, 3'b101, 3'b110: res = 1'b1;
            default:                res = 1'b0;
        endcase
        return res;
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic [3:0]  flush_cnt_r;
    logic [3:0]  flush_cnt_nx_s;

    logic        ready_s;
    logic        accept_s;
    logic [31:0] target_s;
    logic [31:0] seq_pc_s;
    logic        met_s;
    logic        misalign_s;
    logic        taken_s;
    logic [31:0] next_pc_s;

    logic        out_valid_r;
    logic        out_taken_r;
    logic [31:0] out_next_pc_r;
    logic        out_misalign_r;
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] taken_cnt_r;

    // Handshake: only IDLE accepts, and only when the result slot frees up this cycle.
    always_comb begin
        ready_s  = (state_r == IDLE) && (!out_valid_r || out_ready);
        accept_s = in_valid && ready_s;
    end

    // Resolve datapath: target, fall-through address and taken/misalign decision.
    always_comb begin
        target_s   = pc + imm;
        seq_pc_s   = pc + 32'd4;
        met_s      = cond_met(comp_code, rs1_val, rs2_val);
        misalign_s = met_s && (target_s[1:0] != 2'b00);
        taken_s    = met_s && !misalign_s;
        if (taken_s) begin
            next_pc_s = target_s;
        end else begin
            next_pc_s = seq_pc_s;
        end
    end

    // FSM state and flush counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            flush_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_nx_s;
            flush_cnt_r <= flush_cnt_nx_s;
        end
    end

    // FSM next state: a taken accept opens a flush window of FLUSH_CYCLES cycles.
    always_comb begin
        state_nx_s     = state_r;
        flush_cnt_nx_s = flush_cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s && taken_s) begin
                    state_nx_s     = FLUSH;
                    flush_cnt_nx_s = 4'd1;
                end else begin
                    state_nx_s     = IDLE;
                    flush_cnt_nx_s = 4'd0;
                end
            end
            FLUSH: begin
                if (flush_cnt_r >= FLUSH_LIM) begin
                    state_nx_s     = IDLE;
                    flush_cnt_nx_s = 4'd0;
                end else begin
                    state_nx_s     = FLUSH;
                    flush_cnt_nx_s = flush_cnt_r + 4'd1;
                end
            end
            default: begin
                state_nx_s     = IDLE;
                flush_cnt_nx_s = 4'd0;
            end
        endcase
    end

    // Result register: load on accept, drop valid on consume, otherwise hold steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r    <= 1'b0;
            out_taken_r    <= 1'b0;
            out_next_pc_r  <= 32'd0;
            out_misalign_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r    <= 1'b1;
            out_taken_r    <= taken_s;
            out_next_pc_r  <= next_pc_s;
            out_misalign_r <= misalign_s;
        end else if (out_ready) begin
            out_valid_r    <= 1'b0;
        end else begin
            out_valid_r    <= out_valid_r;
        end
    end

    // Saturating statistics counters for accepted and taken branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_r <= '0;
            taken_cnt_r  <= '0;
        end else begin
            if (accept_s && is_branch(comp_code) && (branch_cnt_r != CNT_MAX)) begin
                branch_cnt_r <= branch_cnt_r + CNT_ONE;
            end else begin
                branch_cnt_r <= branch_cnt_r;
            end
            if (accept_s && taken_s && (taken_cnt_r != CNT_MAX)) begin
                taken_cnt_r <= taken_cnt_r + CNT_ONE;
            end else begin
                taken_cnt_r <= taken_cnt_r;
            end
        end
    end

    assign in_ready     = ready_s;
    assign out_valid    = out_valid_r;
    assign out_taken    = out_taken_r;
    assign out_next_pc  = out_next_pc_r;
    assign out_misalign = out_misalign_r;
    assign flush        = (state_r == FLUSH);
    assign branch_cnt   = branch_cnt_r;
    assign taken_cnt    = taken_cnt_r;

endmodule

// File: tb/tb_branch_resolve_unit_rv32i.sv
// Directed self-checking bench for branch_resolve_unit_rv32i.
// Counters are built 4 bits wide so saturation can be reached quickly.
module tb_branch_resolve_unit_rv32i;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    comp_code;
    logic [31:0]   rs1_val;
    logic [31:0]   rs2_val;
    logic [31:0]   pc;
    logic [31:0]   imm;
    logic          out_valid;
    logic          out_ready;
    logic          out_taken;
    logic [31:0]   out_next_pc;
    logic          out_misalign;
    logic          flush;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] taken_cnt;

    int checks;
    int failures;

    branch_resolve_unit_rv32i #(
        .FLUSH_CYCLES(2),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .comp_code(comp_code),
        .rs1_val(rs1_val),
        .rs2_val(rs2_val),
        .pc(pc),
        .imm(imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_taken(out_taken),
        .out_next_pc(out_next_pc),
        .out_misalign(out_misalign),
        .flush(flush),
        .branch_cnt(branch_cnt),
        .taken_cnt(taken_cnt)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [31:0] i);
        in_valid  = v;
        comp_code = c;
        rs1_val   = a;
        rs2_val   = b;
        pc        = p;
        imm       = i;
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_next_pc", out_next_pc, 32'd0);
        chk("rst_taken", {31'd0, out_taken}, 32'd0);
        chk("rst_branch_cnt", {28'd0, branch_cnt}, 32'd0);
        chk("rst_taken_cnt", {28'd0, taken_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // BEQ taken, 2-cycle flush
        drive(1'b1, 3'b001, 32'd5, 32'd5, 32'h100, 32'h20);
        chk("beq_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("beq_out_valid", {31'd0, out_valid}, 32'd1);
        chk("beq_taken", {31'd0, out_taken}, 32'd1);
        chk("beq_next_pc", out_next_pc, 32'h120);
        chk("beq_misalign", {31'd0, out_misalign}, 32'd0);
        chk("beq_flush1", {31'd0, flush}, 32'd1);
        chk("beq_in_ready1", {31'd0, in_ready}, 32'd0);
        chk("beq_taken_cnt", {28'd0, taken_cnt}, 32'd1);
        chk("beq_branch_cnt", {28'd0, branch_cnt}, 32'd1);
        tick();
        chk("beq_flush2", {31'd0, flush}, 32'd1);
        chk("beq_in_ready2", {31'd0, in_ready}, 32'd0);
        chk("beq_consumed", {31'd0, out_valid}, 32'd0);
        tick();
        chk("beq_flush_end", {31'd0, flush}, 32'd0);
        chk("beq_ready_back", {31'd0, in_ready}, 32'd1);

        // BLT signed: -1 < 1 -> taken
        drive(1'b1, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("blt_taken", {31'd0, out_taken}, 32'd1);
        chk("blt_next_pc", out_next_pc, 32'h210);
        chk("blt_flush", {31'd0, flush}, 32'd1);
        tick();
        tick();

        // BLTU unsigned: 0xFFFFFFFF < 1 false -> not taken
        drive(1'b1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("bltu_valid", {31'd0, out_valid}, 32'd1);
        chk("bltu_taken", {31'd0, out_taken}, 32'd0);
        chk("bltu_next_pc", out_next_pc, 32'h204);
        chk("bltu_flush", {31'd0, flush}, 32'd0);
        chk("bltu_branch_cnt", {28'd0, branch_cnt}, 32'd3);
        chk("bltu_taken_cnt", {28'd0, taken_cnt}, 32'd2);

        // BNE taken condition but misaligned target
        drive(1'b1, 3'b010, 32'd1, 32'd2, 32'h300, 32'h6);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("bne_taken", {31'd0, out_taken}, 32'd0);
        chk("bne_misalign", {31'd0, out_misalign}, 32'd1);
        chk("bne_next_pc", out_next_pc, 32'h304);
        chk("bne_flush", {31'd0, flush}, 32'd0);
        chk("bne_branch_cnt", {28'd0, branch_cnt}, 32'd4);
        chk("bne_taken_cnt", {28'd0, taken_cnt}, 32'd2);

        // BGE signed -1 >= 1 false, accepted while previous result is consumed
        drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h8);
        chk("bge_ready_on_consume", {31'd0, in_ready}, 32'd1);
        tick();
        // Backpressure with a pending BGEU (unsigned 0xFFFFFFFF >= 1 -> taken)
        out_ready = 1'b0;
        drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h500, 32'h40);
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_next_pc", out_next_pc, 32'h404);
            chk("bp_taken", {31'd0, out_taken}, 32'd0);
            chk("bp_misalign", {31'd0, out_misalign}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("bgeu_valid", {31'd0, out_valid}, 32'd1);
        chk("bgeu_taken", {31'd0, out_taken}, 32'd1);
        chk("bgeu_next_pc", out_next_pc, 32'h540);
        chk("bgeu_flush", {31'd0, flush}, 32'd1);
        chk("bgeu_branch_cnt", {28'd0, branch_cnt}, 32'd6);
        chk("bgeu_taken_cnt", {28'd0, taken_cnt}, 32'd3);
        tick();
        tick();

        // Wrap-around target
        drive(1'b1, 3'b110, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h20);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("wrap_taken", {31'd0, out_taken}, 32'd1);
        chk("wrap_next_pc", out_next_pc, 32'h10);
        tick();
        tick();

        // comp_code none and reserved: never taken, never misaligned, not counted
        drive(1'b1, 3'b000, 32'd9, 32'd9, 32'h600, 32'h8);
        tick();
        chk("none_taken", {31'd0, out_taken}, 32'd0);
        chk("none_next_pc", out_next_pc, 32'h604);
        drive(1'b1, 3'b111, 32'd9, 32'd9, 32'h700, 32'h6);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("rsv_taken", {31'd0, out_taken}, 32'd0);
        chk("rsv_misalign", {31'd0, out_misalign}, 32'd0);
        chk("rsv_next_pc", out_next_pc, 32'h704);
        chk("rsv_flush", {31'd0, flush}, 32'd0);
        chk("rsv_branch_cnt", {28'd0, branch_cnt}, 32'd7);

        // Back-to-back not-taken BNE drive branch_cnt into saturation (7 + 10 -> 15)
        drive(1'b1, 3'b010, 32'd4, 32'd4, 32'h800, 32'h8);
        for (int k = 0; k < 10; k++) begin
            tick();
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("sat_branch_cnt", {28'd0, branch_cnt}, 32'd15);
        chk("sat_taken_cnt", {28'd0, taken_cnt}, 32'd4);
        chk("sat_next_pc", out_next_pc, 32'h804);

        // Taken BEQ, then reset during the first flush cycle
        drive(1'b1, 3'b001, 32'd1, 32'd1, 32'h900, 32'h40);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("pre_rst_flush", {31'd0, flush}, 32'd1);
        chk("pre_rst_branch_sat", {28'd0, branch_cnt}, 32'd15);
        chk("pre_rst_taken_cnt", {28'd0, taken_cnt}, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flush", {31'd0, flush}, 32'd0);
        chk("mid_rst_branch_cnt", {28'd0, branch_cnt}, 32'd0);
        chk("mid_rst_taken_cnt", {28'd0, taken_cnt}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("rel_flush", {31'd0, flush}, 32'd0);
        chk("rel_in_ready2", {31'd0, in_ready}, 32'd1);
        tick();
        chk("rel_flush2", {31'd0, flush}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit_rv32i.md
BRANCH_RESOLVE_UNIT_RV32I -- requirements
Module: branch_resolve_unit_rv32i

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: cycles `flush` is held after a taken branch; legal range 1..15.
REQ-002 Parameter CNT_W, default 32: width of the statistics counters.
REQ-003 `clk`  in  1  single clock; every register samples on the rising edge.
REQ-004 `rst_n`  in  1  reset, asynchronous assert, active-low.
REQ-005 `in_valid`  in  1  upstream presents a resolvable instruction.
REQ-006 `in_ready`  out  1  unit accepts this cycle.
REQ-007 `comp_code`  in  3  condition from the branch condition decoder.
REQ-008 `rs1_val`  in  32  first operand.
REQ-009 `rs2_val`  in  32  second operand.
REQ-010 `pc`  in  32  instruction address.
REQ-011 `imm`  in  32  sign-extended B-immediate.
REQ-012 `out_valid`  out  1  result register holds a result.
REQ-013 `out_ready`  in  1  downstream consumes the result.
REQ-014 `out_taken`  out  1  branch taken.
REQ-015 `out_next_pc`  out  32  resolved next fetch address.
REQ-016 `out_misalign`  out  1  taken target not word-aligned.
REQ-017 `flush`  out  1  kill younger in-flight instructions.
REQ-018 `branch_cnt`  out  CNT_W  accepted branches.
REQ-019 `taken_cnt`  out  CNT_W  taken branches.

Function
REQ-020 comp_code encoding:
- 000 none
- 001 BEQ
- 010 BNE
- 011 BLT (signed)
- 100 BGE (signed)
- 101 BLTU
- 110 BGEU
- 111 reserved, resolves not-taken.
REQ-021 Accept when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-022 Latency 1: results are registered on accept; out_valid rises the following cycle.
REQ-023 Output fields are stable while out_valid && !out_ready.
REQ-024 out_valid clears on out_ready when no new accept occurs that cycle.
REQ-025 Simultaneous consume and accept replaces the result with no bubble.
REQ-026 Target = pc + imm modulo 2^32; wrap-around is silent.
REQ-027 Condition met and target[1:0]==00: out_taken=1, out_next_pc=target.
REQ-028 Condition not met: out_taken=0, out_next_pc = pc + 4 modulo 2^32.
REQ-029 Condition met and target[1:0]!=00:
- out_taken=0, out_misalign=1, out_next_pc = pc + 4
- no flush is issued.
REQ-030 comp_code 000 or 111: out_taken=0, out_misalign=0, out_next_pc = pc + 4.
REQ-031 FSM states IDLE and FLUSH. IDLE->FLUSH on accept with out_taken=1. FLUSH->IDLE when the flush counter reaches FLUSH_CYCLES.
REQ-032 flush=1 exactly while state==FLUSH: FLUSH_CYCLES cycles, starting the cycle after accept.
REQ-033 in_ready=0 throughout FLUSH.
REQ-034 The taken result may be consumed during FLUSH.
REQ-035 Back-to-back taken branches are impossible, since a second accept cannot occur in FLUSH.
REQ-036 branch_cnt increments on accept with comp_code in 001..110.
REQ-037 taken_cnt increments on accept with out_taken=1.
REQ-038 Both counters saturate at 2^CNT_W-1 and do not wrap.
REQ-039 The unit has no combinational in->out path apart from in_ready's dependence on out_ready.

Reset
REQ-040 rst_n=0 forces asynchronously:
- state=IDLE, flush counter=0
- out_valid=0, out_taken=0, out_misalign=0, out_next_pc=0
- flush=0, branch_cnt=0, taken_cnt=0.
REQ-041 Reset during FLUSH drops flush immediately; no flush cycles resume after release.
REQ-042 in_ready is 1 in the first cycle after rst_n deasserts.

Verification
REQ-043 BEQ, rs1=rs2=5, pc=0x100, imm=0x20 -> next cycle: out_valid=1, taken=1, next_pc=0x120; flush=1 for 2 cycles; in_ready=0 for 2 cycles; taken_cnt=1.
REQ-044 BLT vs BLTU, rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=0x10:
- BLT -> taken, next_pc=0x210
- BLTU -> not taken, next_pc=0x204.
REQ-045 BNE, rs1=1, rs2=2, pc=0x300, imm=0x6 -> taken=0, misalign=1, next_pc=0x304, flush=0, branch_cnt increments.
REQ-046 Backpressure: hold out_ready=0 for 3 cycles after a result -> in_ready=0 and outputs stable. Then out_ready=1 with in_valid=1 -> new result next cycle with no bubble.
REQ-047 Wrap-around: BGEU, rs1=rs2=0, pc=0xFFFFFFF0, imm=0x20 -> next_pc=0x00000010.
REQ-048 Reset: rst_n low in the 1st flush cycle -> flush=0 and counters=0 immediately; in_ready=1 after release.
